// File: rtl/registers_bank_dumper.sv
// ---------------------------------------------------------------------------
// registers_bank_dumper
//
// Captures a flattened register bank on i_start. It then streams the bank out
// one byte at a time over a valid/ready handshake. Registers go out in
// ascending order, and the bytes of each register go out LSB first. A
// one-cycle o_done pulse follows the last accepted byte.
//
// Optional feature:
//   REGISTERS_BANK_DUMPER_HEADER_EN - when defined, a single 8'hA5 header byte
//   is offered before the first register byte, using the same handshake.
//
// Parameters:
//   REGISTERS_BANK_SIZE - number of registers in the bank
//   REGISTERS_SIZE      - register width in bits (non-zero multiple of 8)
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous reset, active low
//   i_start      request a dump (only honoured while idle)
//   i_bus_debug  flattened bank, register j at [(j+1)*REGISTERS_SIZE-1 -: REGISTERS_SIZE]
//   i_ready      consumer accepts o_byte this cycle
//   o_byte       offered byte
//   o_valid      o_byte is valid
//   o_busy       dump in progress
//   o_done       one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module registers_bank_dumper #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic                                          i_start,
    input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
    input  logic                                          i_ready,
    output logic [7:0]                                    o_byte,
    output logic                                          o_valid,
    output logic                                          o_busy,
    output logic                                          o_done
);

    localparam int NB = REGISTERS_SIZE / 8;
    localparam int RW = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int W  = REGISTERS_BANK_SIZE * REGISTERS_SIZE;

    localparam logic [RW-1:0] LAST_R = RW'(REGISTERS_BANK_SIZE - 1);
    localparam logic [KW-1:0] LAST_K = KW'(NB - 1);

`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_DONE   = 2'd2
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
        ,S_HEADER = 2'd3
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    snap_q,  snap_d;
    logic [RW-1:0]   reg_q,   reg_d;
    logic [KW-1:0]   byte_q,  byte_d;
    logic [7:0]      obyte_q, obyte_d;
    logic            valid_q, valid_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic            xfer;

    // Byte-addressable view of the next snapshot: [register][byte][bit].
    logic [REGISTERS_BANK_SIZE-1:0][NB-1:0][7:0] snap_view;
    assign snap_view = snap_d;

    // A byte moves only while it is actually offered.
    assign xfer = valid_q & i_ready;

    // Next-state logic. Every output register is computed from the next
    // state. As a result, o_byte and o_valid hold still automatically
    // whenever nothing advances.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        reg_d   = reg_q;
        byte_d  = byte_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    snap_d  = i_bus_debug;
                    reg_d   = '0;
                    byte_d  = '0;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
                    state_d = S_HEADER;
`else
                    state_d = S_SEND;
`endif
                end
            end
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
            S_HEADER: begin
                if (xfer) state_d = S_SEND;
            end
`endif
            S_SEND: begin
                if (xfer) begin
                    if (byte_q == LAST_K) begin
                        byte_d = '0;
                        if (reg_q == LAST_R) state_d = S_DONE;
                        else                 reg_d   = reg_q + RW'(1);
                    end else begin
                        byte_d = byte_q + KW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered output values, derived from the next state.
    always_comb begin
        valid_d = 1'b0;
        obyte_d = 8'h00;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        if (state_d == S_SEND) begin
            valid_d = 1'b1;
            obyte_d = snap_view[reg_d][byte_d];
        end
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
        if (state_d == S_HEADER) begin
            valid_d = 1'b1;
            obyte_d = HEADER_BYTE;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            reg_q   <= '0;
            byte_q  <= '0;
            obyte_q <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            reg_q   <= reg_d;
            byte_q  <= byte_d;
            obyte_q <= obyte_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_byte  = obyte_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_registers_bank_dumper.sv
// ---------------------------------------------------------------------------
// Directed bench for registers_bank_dumper at default parameters.
// Register j is loaded with 32'h11223300 + j. Expected bytes are derived from
// that pattern. Honours REGISTERS_BANK_DUMPER_HEADER_EN for the A5 header.
// ---------------------------------------------------------------------------
module tb_registers_bank_dumper;

    localparam int BANK = 32;
    localparam int RS   = 32;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
    localparam int TOTAL = BANK * RS / 8 + 1;
`else
    localparam int TOTAL = BANK * RS / 8;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [BANK*RS-1:0]   bus;
    logic                 ready;
    logic [7:0]           obyte;
    logic                 valid;
    logic                 busy;
    logic                 done;

    int errors = 0;
    int checks = 0;

    registers_bank_dumper #(
        .REGISTERS_BANK_SIZE (BANK),
        .REGISTERS_SIZE      (RS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_bus_debug (bus),
        .i_ready     (ready),
        .o_byte      (obyte),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n);
        int          m;
        logic [31:0] w;
        m = n;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
        if (m == 0) return 8'hA5;
        m = m - 1;
`endif
        w = 32'h11223300 + 32'(m / 4);
        return w[8*(m % 4) +: 8];
    endfunction

    task automatic load_bus();
        for (int j = 0; j < BANK; j++) bus[j*RS +: RS] = 32'h11223300 + 32'(j);
    endtask

    // One dump. The caller is at a negedge, idle.
    //   rdy_mode 0: ready always high; 1: pattern 1,0,0,1 repeating
    //   chg:      flood the bus with ones two cycles after start
    //   spam:     keep pulsing i_start during the dump
    //   abort_at: >0 -> reset after that many accepted bytes
    task automatic run(input int rdy_mode, input bit chg, input bit spam, input int abort_at);
        int         acc;
        int         dones;
        int         cyc;
        bit         hold;
        bit         fin;
        bit         r;
        logic [7:0] prev;
        acc = 0; dones = 0; cyc = 0; hold = 0; fin = 0; prev = 8'h00;
        start = 1'b1;
        ready = (rdy_mode == 0) ? 1'b1 : 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("latency1_valid", {31'b0, valid}, 32'd1);
        while (!fin && cyc < 2000) begin
            if (abort_at > 0 && acc == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("abort_valid", {31'b0, valid}, 32'd0);
                chk("abort_busy",  {31'b0, busy},  32'd0);
                chk("abort_done",  {31'b0, done},  32'd0);
                chk("abort_byte",  {24'b0, obyte}, 32'd0);
                rst_n = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (valid !== 1'b0 || done !== 1'b0) begin
                        chk("abort_quiet", {30'b0, valid, done}, 32'd0);
                    end
                end
                chk("abort_quiet_end", {30'b0, valid, done}, 32'd0);
                fin = 1;
                break;
            end
            if (done === 1'b1) begin
                start = 1'b0;
                dones++;
                chk("done_valid", {31'b0, valid}, 32'd0);
                chk("done_busy",  {31'b0, busy},  32'd1);
                chk("done_count", 32'(acc), 32'(TOTAL));
                @(negedge clk);
                chk("after_done_busy",  {31'b0, busy},  32'd0);
                chk("after_done_pulse", {31'b0, done},  32'd0);
                chk("after_done_valid", {31'b0, valid}, 32'd0);
                fin = 1;
                break;
            end
            if (valid !== 1'b1 || busy !== 1'b1) begin
                chk("stream_valid_busy", {30'b0, valid, busy}, 32'd3);
            end
            if (hold && obyte !== prev) chk("hold_stable", {24'b0, obyte}, {24'b0, prev});
            if (obyte !== exp_byte(acc)) chk($sformatf("byte%0d", acc), {24'b0, obyte}, {24'b0, exp_byte(acc)});
            if (acc == 0 || acc == 1 || acc == TOTAL - 1) chk($sformatf("byte%0d", acc), {24'b0, obyte}, {24'b0, exp_byte(acc)});
            r = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            ready = r;
            start = spam && (cyc % 3 == 1);
            if (chg && cyc == 1) bus = '1;
            hold = !r;
            prev = obyte;
            if (r) acc++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        load_bus();
        chk("run_finished", {31'b0, fin}, 32'd1);
        if (abort_at == 0) begin
            chk("bytes_total", 32'(acc), 32'(TOTAL));
            chk("done_pulses", 32'(dones), 32'd1);
        end else begin
            chk("abort_no_done", 32'(dones), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        load_bus();
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_byte",  {24'b0, obyte}, 32'd0);

        // A start that arrives together with reset must lose.
        start = 1'b1;
        @(negedge clk);
        chk("rst_prio_valid", {31'b0, valid}, 32'd0);
        chk("rst_prio_busy",  {31'b0, busy},  32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        run(0, 1'b0, 1'b0, 0);   // plain dump, ready held high
        repeat (2) @(negedge clk);
        run(1, 1'b0, 1'b0, 0);   // ready pattern 1,0,0,1
        repeat (2) @(negedge clk);
        run(0, 1'b1, 1'b0, 0);   // bus changes after start
        repeat (2) @(negedge clk);
        run(1, 1'b0, 1'b1, 0);   // repeated start mid-dump
        repeat (2) @(negedge clk);
        run(0, 1'b0, 1'b0, 10);  // reset after byte 10
        run(0, 1'b0, 1'b0, 0);   // full dump after the abort

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
